data_mem_arbiter: RTL and testbench

//   Shares the single-port data_mem (8-bit addr/data, comb read, posedge write)

---
 rtl/data_mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Arbiter sharing the single-port data memory between the core load/store
// unit (port 0) and the loader/DMA (port 1). Round-robin tenure with a
// bounded burst length whenever the other port is waiting.
module data_mem_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic [DW-1:0] r0_rdata,
    output logic          r0_rvalid,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic [DW-1:0] r1_rdata,
    output logic          r1_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_read,
    output logic          mem_write,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          last_owner_q, last_owner_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic [DW-1:0] r0_rdata_q, r0_rdata_d;
    logic [DW-1:0] r1_rdata_q, r1_rdata_d;
    logic          r0_rvalid_q, r0_rvalid_d;
    logic          r1_rvalid_q, r1_rvalid_d;

    logic          own0;
    logic          own1;
    logic          sel_req;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          other_req;
    state_e        other_state;
    logic          accept;

    // Memory-side mux: the owning port drives memory; reset blocks any access
    always_comb begin
        own0        = (state_q == OWN0) && !Reset;
        own1        = (state_q == OWN1) && !Reset;
        sel_req     = 1'b0;
        sel_we      = 1'b0;
        sel_addr    = '0;
        sel_wdata   = '0;
        other_req   = 1'b0;
        other_state = IDLE;
        if (own0) begin
            sel_req     = r0_req;
            sel_we      = r0_we;
            sel_addr    = r0_addr;
            sel_wdata   = r0_wdata;
            other_req   = r1_req;
            other_state = OWN1;
        end else if (own1) begin
            sel_req     = r1_req;
            sel_we      = r1_we;
            sel_addr    = r1_addr;
            sel_wdata   = r1_wdata;
            other_req   = r0_req;
            other_state = OWN0;
        end
        accept    = sel_req;
        mem_read  = accept && !sel_we;
        mem_write = accept && sel_we;
        mem_addr  = accept ? sel_addr : '0;
        mem_wdata = accept ? sel_wdata : '0;
    end

    // Next tenure, burst accounting and read-data return for the winning port
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        r0_rdata_d   = r0_rdata_q;
        r1_rdata_d   = r1_rdata_q;
        r0_rvalid_d  = 1'b0;
        r1_rvalid_d  = 1'b0;

        if (mem_read) begin
            if (own0) begin
                r0_rdata_d  = mem_rdata;
                r0_rvalid_d = 1'b1;
            end else begin
                r1_rdata_d  = mem_rdata;
                r1_rvalid_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                burst_cnt_d = '0;
                if (r0_req && r1_req) begin
                    state_d = last_owner_q ? OWN0 : OWN1;
                end else if (r0_req) begin
                    state_d = OWN0;
                end else if (r1_req) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!sel_req) begin
                    last_owner_d = (state_q == OWN1);
                    burst_cnt_d  = '0;
                    state_d      = other_req ? other_state : IDLE;
                end else if ((burst_cnt_q == BURST_LAST) && other_req) begin
                    last_owner_d = (state_q == OWN1);
                    burst_cnt_d  = '0;
                    state_d      = other_state;
                end else if (burst_cnt_q != BURST_LAST) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    // State and returned-data registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            burst_cnt_q  <= '0;
            r0_rdata_q   <= '0;
            r1_rdata_q   <= '0;
            r0_rvalid_q  <= 1'b0;
            r1_rvalid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            r0_rdata_q   <= r0_rdata_d;
            r1_rdata_q   <= r1_rdata_d;
            r0_rvalid_q  <= r0_rvalid_d;
            r1_rvalid_q  <= r1_rvalid_d;
        end
    end

    assign r0_gnt    = own0;
    assign r1_gnt    = own1;
    assign r0_rdata  = r0_rdata_q;
    assign r1_rdata  = r1_rdata_q;
    assign r0_rvalid = r0_rvalid_q;
    assign r1_rvalid = r1_rvalid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios followed by random traffic,
// everything checked against a transaction-level model of the arbiter and memory.
module tb_data_mem_arbiter;

    localparam int MAX_BURST = 4;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       r0_req, r0_we, r1_req, r1_we;
    logic [7:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic       r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [7:0] r0_rdata, r1_rdata;
    logic [7:0] mem_addr, mem_wdata;
    logic       mem_read, mem_write, busy;
    wire  [7:0] mem_rdata;

    logic [7:0] env_mem [256];
    bit         mem_loaded = 1'b0;

    int         check_count = 0;
    int         pass_count  = 0;
    int         fail_count  = 0;

    int         m_owner;
    int         m_last;
    int         m_count;
    logic [7:0] m_rdata [2];
    bit         m_rvalid [2];
    logic [7:0] ref_mem [256];
    bit         model_valid = 1'b0;

    data_mem_arbiter #(.AW(8), .DW(8), .MAX_BURST(MAX_BURST)) dut (
        .CLK(CLK), .Reset(Reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rdata(r0_rdata), .r0_rvalid(r0_rvalid),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rdata(r1_rdata), .r1_rvalid(r1_rvalid),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Free-running clock
    always #5 CLK = ~CLK;

    // Behavioural data_mem: combinational read, posedge write, known start contents
    assign mem_rdata = mem_read ? env_mem[mem_addr] : 8'hzz;
    always @(posedge CLK) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= 8'(i * 37 + 11);
            mem_loaded <= 1'b1;
        end else if (mem_write) begin
            env_mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int port, input bit req, input bit we,
                                 input logic [7:0] addr, input logic [7:0] wdata);
        if (port == 0) begin
            r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata;
        end else begin
            r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata;
        end
    endtask

    // At the falling edge: compare every output with the model, then advance the model
    task automatic sampleCycle();
        bit         rq [2];
        bit         wq [2];
        logic [7:0] ad [2];
        logic [7:0] wd [2];
        bit         acc, exp_rd, exp_wr;
        logic [7:0] exp_addr, exp_wdata;
        int         o, oth;
        @(negedge CLK);
        rq[0] = r0_req; wq[0] = r0_we; ad[0] = r0_addr; wd[0] = r0_wdata;
        rq[1] = r1_req; wq[1] = r1_we; ad[1] = r1_addr; wd[1] = r1_wdata;
        o = m_owner;
        acc = 0; exp_rd = 0; exp_wr = 0; exp_addr = 8'h00; exp_wdata = 8'h00;
        if (!Reset && o >= 0) begin
            if (rq[o]) begin
                acc = 1; exp_rd = !wq[o]; exp_wr = wq[o];
                exp_addr = ad[o]; exp_wdata = wd[o];
            end
        end
        if (model_valid) begin
            checkOutput("r0_gnt", r0_gnt, !Reset && o == 0);
            checkOutput("r1_gnt", r1_gnt, !Reset && o == 1);
            checkOutput("busy", busy, o >= 0);
            checkOutput("mem_read", mem_read, exp_rd);
            checkOutput("mem_write", mem_write, exp_wr);
            checkOutput("mem_addr", mem_addr, exp_addr);
            checkOutput("mem_wdata", mem_wdata, exp_wdata);
            checkOutput("r0_rvalid", r0_rvalid, m_rvalid[0]);
            checkOutput("r1_rvalid", r1_rvalid, m_rvalid[1]);
            checkOutput("r0_rdata", r0_rdata, m_rdata[0]);
            checkOutput("r1_rdata", r1_rdata, m_rdata[1]);
            checkOutput("rw_exclusive", mem_read && mem_write, 0);
        end
        if (Reset) begin
            m_owner = -1; m_last = 1; m_count = 0;
            m_rvalid[0] = 0; m_rvalid[1] = 0;
            m_rdata[0] = 8'h00; m_rdata[1] = 8'h00;
            model_valid = 1'b1;
        end else if (model_valid) begin
            m_rvalid[0] = 0; m_rvalid[1] = 0;
            if (acc) begin
                if (wq[o]) ref_mem[ad[o]] = wd[o];
                else begin
                    m_rdata[o] = ref_mem[ad[o]];
                    m_rvalid[o] = 1;
                end
            end
            if (o < 0) begin
                m_count = 0;
                if (rq[0] && rq[1]) m_owner = 1 - m_last;
                else if (rq[0]) m_owner = 0;
                else if (rq[1]) m_owner = 1;
            end else begin
                oth = 1 - o;
                if (!rq[o]) begin
                    m_last = o; m_count = 0;
                    m_owner = rq[oth] ? oth : -1;
                end else begin
                    m_count++;
                    if (m_count >= MAX_BURST && rq[oth]) begin
                        m_last = o; m_owner = oth; m_count = 0;
                    end
                end
            end
        end
    endtask

    task automatic finishCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset();
        Reset = 1'b1;
        applyStimulus(0, 0, 0, 8'h00, 8'h00);
        applyStimulus(1, 0, 0, 8'h00, 8'h00);
        sampleCycle();
        finishCycle();
        Reset = 1'b0;
    endtask

    initial begin
        int idx0, before_r1, k, first_acc, last_acc, j, n, r0_pending;
        bit r1_done, got, r1_pend, r0_acc;
        bit rq [2];
        bit rw [2];
        logic [7:0] ra [2];
        logic [7:0] rd [2];
        bit acc_prev [2];

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
        Reset = 1'b1;
        applyStimulus(0, 0, 0, 8'h00, 8'h00);
        applyStimulus(1, 0, 0, 8'h00, 8'h00);
        @(posedge CLK);
        #1;

        // Reset state
        sampleCycle();
        finishCycle();
        sampleCycle();
        checkOutput("rst_r0_gnt", r0_gnt, 0);
        checkOutput("rst_r1_gnt", r1_gnt, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rvalid", {r0_rvalid, r1_rvalid}, 0);
        checkOutput("rst_rdata", {r0_rdata, r1_rdata}, 0);
        checkOutput("rst_mem_ctl", {mem_read, mem_write}, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        finishCycle();
        Reset = 1'b0;

        // Scenario 1: single write then read back through port 0
        $display("[TB] scenario 1: basic write/read");
        applyStimulus(0, 1, 1, 8'h10, 8'hA5);
        sampleCycle();
        checkOutput("t1_latency_gnt", r0_gnt, 0);
        finishCycle();
        sampleCycle();
        checkOutput("t1_gnt", r0_gnt, 1);
        checkOutput("t1_mem_write", mem_write, 1);
        checkOutput("t1_mem_addr", mem_addr, 8'h10);
        checkOutput("t1_mem_wdata", mem_wdata, 8'hA5);
        finishCycle();
        applyStimulus(0, 1, 0, 8'h10, 8'h00);
        sampleCycle();
        checkOutput("t1_mem_read", mem_read, 1);
        finishCycle();
        applyStimulus(0, 0, 0, 8'h00, 8'h00);
        sampleCycle();
        checkOutput("t1_rvalid", r0_rvalid, 1);
        checkOutput("t1_rdata", r0_rdata, 8'hA5);
        finishCycle();

        // Scenario 2: simultaneous requests after reset, direct hand-over
        $display("[TB] scenario 2: first arbitration and hand-over");
        doReset();
        applyStimulus(0, 1, 0, 8'h01, 8'h00);
        applyStimulus(1, 1, 0, 8'h02, 8'h00);
        sampleCycle();
        finishCycle();
        sampleCycle();
        checkOutput("t2_r0_first", r0_gnt, 1);
        checkOutput("t2_r1_waits", r1_gnt, 0);
        finishCycle();
        applyStimulus(0, 0, 0, 8'h00, 8'h00);
        sampleCycle();
        checkOutput("t2_busy_drop", busy, 1);
        finishCycle();
        sampleCycle();
        checkOutput("t2_r1_gnt", r1_gnt, 1);
        checkOutput("t2_busy_handover", busy, 1);
        finishCycle();

        // Scenario 3: port 0 burst is capped while port 1 waits
        $display("[TB] scenario 3: bounded burst");
        doReset();
        idx0 = 0; before_r1 = -1; r1_done = 0;
        for (int c = 0; c < 80 && idx0 < 10; c++) begin
            applyStimulus(0, 1, 0, 8'(idx0), 8'h00);
            applyStimulus(1, !r1_done, 0, 8'h40, 8'h00);
            sampleCycle();
            if (r0_gnt && r0_req) idx0++;
            if (r1_gnt && r1_req) begin
                r1_done = 1; before_r1 = idx0;
            end
            finishCycle();
        end
        checkOutput("t3_r0_burst", before_r1, 4);
        checkOutput("t3_r0_total", idx0, 10);

        // Scenario 4: port 1 streams writes alone, port 0 reads them back
        $display("[TB] scenario 4: unbroken stream and readback");
        doReset();
        k = 0; first_acc = -1; last_acc = -1;
        for (int c = 0; c < 40 && k < 6; c++) begin
            applyStimulus(1, 1, 1, 8'h20 + 8'(k), 8'(k + 1));
            applyStimulus(0, 0, 0, 8'h00, 8'h00);
            sampleCycle();
            if (r1_gnt && r1_req) begin
                if (first_acc < 0) first_acc = c;
                last_acc = c;
                k++;
            end
            finishCycle();
        end
        checkOutput("t4_accepts", k, 6);
        checkOutput("t4_span", last_acc - first_acc, 5);
        j = 0; n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            applyStimulus(0, j < 6, 0, 8'h20 + 8'(j), 8'h00);
            applyStimulus(1, 0, 0, 8'h00, 8'h00);
            sampleCycle();
            if (r0_rvalid) begin
                checkOutput("t4_readback", r0_rdata, 32'(n + 1));
                n++;
            end
            if (r0_gnt && r0_req) j++;
            finishCycle();
        end
        checkOutput("t4_reads", n, 6);

        // Scenario 5: reset in the middle of a port 0 burst
        $display("[TB] scenario 5: reset mid-burst");
        doReset();
        applyStimulus(0, 1, 1, 8'h50, 8'hE0);
        sampleCycle();
        finishCycle();
        sampleCycle();
        finishCycle();
        Reset = 1'b1;
        applyStimulus(0, 1, 1, 8'h51, 8'hE1);
        sampleCycle();
        checkOutput("t5_rst_no_write", mem_write, 0);
        finishCycle();
        Reset = 1'b0;
        applyStimulus(1, 1, 0, 8'h00, 8'h00);
        sampleCycle();
        checkOutput("t5_gnt_cleared", {r0_gnt, r1_gnt}, 0);
        checkOutput("t5_mem_write", mem_write, 0);
        checkOutput("t5_rvalid", {r0_rvalid, r1_rvalid}, 0);
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_mem_51_kept", env_mem[8'h51], ref_mem[8'h51]);
        checkOutput("t5_mem_50_written", env_mem[8'h50], 8'hE0);
        finishCycle();
        sampleCycle();
        checkOutput("t5_r0_wins", r0_gnt, 1);
        checkOutput("t5_r1_waits", r1_gnt, 0);
        finishCycle();

        // Scenario 6: port 1 writes, hands over, port 0 reads the same location
        $display("[TB] scenario 6: cross-port write then read");
        doReset();
        r1_pend = 1; r0_acc = 0; got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            applyStimulus(1, r1_pend, 1, 8'h7F, 8'h3C);
            applyStimulus(0, c > 0 && !r0_acc, 0, 8'h7F, 8'h00);
            sampleCycle();
            if (r1_gnt && r1_req) r1_pend = 0;
            if (r0_gnt && r0_req) r0_acc = 1;
            if (r0_rvalid) begin
                checkOutput("t6_rdata", r0_rdata, 8'h3C);
                got = 1;
            end
            finishCycle();
        end
        checkOutput("t6_read_returned", got, 1);

        // Random traffic: requests held until accepted, occasional resets
        $display("[TB] random traffic");
        for (int p = 0; p < 2; p++) begin
            rq[p] = 0; rw[p] = 0; ra[p] = 8'h00; rd[p] = 8'h00; acc_prev[p] = 0;
        end
        r0_pending = 0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!rq[p] || acc_prev[p]) begin
                    rq[p] = ($urandom_range(0, 9) < 6);
                    rw[p] = 1'($urandom_range(0, 1));
                    ra[p] = 8'($urandom_range(0, 15));
                    rd[p] = 8'($urandom);
                end
            end
            Reset = ($urandom_range(0, 49) == 0);
            applyStimulus(0, rq[0], rw[0], ra[0], rd[0]);
            applyStimulus(1, rq[1], rw[1], ra[1], rd[1]);
            sampleCycle();
            acc_prev[0] = r0_gnt && r0_req;
            acc_prev[1] = r1_gnt && r1_req;
            if (acc_prev[0]) r0_pending++;
            finishCycle();
        end
        Reset = 1'b0;
        checkOutput("rand_r0_progress", r0_pending > 0, 1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
